// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
package loader_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    // Every multi-byte field in the stream arrives high byte first.
    localparam bit HI_FIRST = 1'b1;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_CNT_HI = 4'd1;
    localparam logic [3:0] S_CNT_LO = 4'd2;
    localparam logic [3:0] S_W_HI   = 4'd3;
    localparam logic [3:0] S_W_LO   = 4'd4;
    localparam logic [3:0] S_CHK_HI = 4'd5;
    localparam logic [3:0] S_CHK_LO = 4'd6;
    localparam logic [3:0] S_DONE   = 4'd7;
    localparam logic [3:0] S_ERR    = 4'd8;

    function automatic logic is_active(input logic [3:0] s);
        return (s == S_CNT_HI) || (s == S_CNT_LO) ||
               (s == S_W_HI)   || (s == S_W_LO)   ||
               (s == S_CHK_HI) || (s == S_CHK_LO);
    endfunction

    function automatic logic is_hi(input logic [3:0] s);
        return (s == S_CNT_HI) || (s == S_W_HI) || (s == S_CHK_HI);
    endfunction

    function automatic logic is_lo(input logic [3:0] s);
        return (s == S_CNT_LO) || (s == S_W_LO) || (s == S_CHK_LO);
    endfunction

endpackage

// File: rtl/byte_pair_assembler.sv
// Joins two consecutive stream bytes into one 16-bit field.
module byte_pair_assembler
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              hi_en,
    input  logic              lo_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    logic [BYTE_W-1:0] hi_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
        end else if (hi_en) begin
            hi_q <= byte_in;
        end
    end

    // The low byte is used straight off the bus in its transfer cycle.
    assign word = HI_FIRST ? {hi_q, byte_in} : {byte_in, hi_q};
    assign word_valid = lo_en;

endmodule

// File: rtl/im_loader.sv
// Streams a counted, checksummed image into instruction memory
// while holding the core's PC.
module im_loader
    import loader_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          MAX_WORDS = 4096
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Start,
    input  logic [7:0]  ByteIn,
    input  logic        ByteValid,
    output logic        ByteReady,
    output logic [15:0] IMAddr,
    output logic [15:0] IMData,
    output logic        IMWrite,
    output logic        Busy,
    output logic        CPUHold,
    output logic        Done,
    output logic        Error
);

    logic [3:0]        state;
    logic [WORD_W-1:0] idx;
    logic [WORD_W-1:0] idx_next;
    logic [WORD_W-1:0] count;
    logic [WORD_W-1:0] sum;
    logic [WORD_W-1:0] word;
    logic              word_valid;
    logic              xfer;

    assign ByteReady = is_active(state);
    assign Busy      = ByteReady;
    assign CPUHold   = Busy;
    assign Done      = (state == S_DONE);
    assign Error     = (state == S_ERR);
    assign xfer      = ByteValid && ByteReady;
    assign idx_next  = idx + 16'd1;

    byte_pair_assembler u_asm (
        .clk        (CLK),
        .reset      (Reset),
        .hi_en      (xfer && is_hi(state)),
        .lo_en      (xfer && is_lo(state)),
        .byte_in    (ByteIn),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state   <= S_IDLE;
            idx     <= '0;
            count   <= '0;
            sum     <= '0;
            IMAddr  <= BASE_ADDR;
            IMData  <= '0;
            IMWrite <= 1'b0;
        end else begin
            IMWrite <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (Start) begin
                        state <= S_CNT_HI;
                        idx   <= '0;
                        sum   <= '0;
                    end
                end
                S_CNT_HI: if (xfer) state <= S_CNT_LO;
                S_CNT_LO: begin
                    if (word_valid) begin
                        count <= word;
                        if (32'(word) > MAX_WORDS)
                            state <= S_ERR;
                        else if (word == '0)
                            state <= S_CHK_HI;
                        else
                            state <= S_W_HI;
                    end
                end
                S_W_HI: if (xfer) state <= S_W_LO;
                S_W_LO: begin
                    if (word_valid) begin
                        IMData  <= word;
                        IMAddr  <= BASE_ADDR + idx;
                        IMWrite <= 1'b1;
                        sum     <= sum + word;
                        idx     <= idx_next;
                        state   <= (idx_next == count) ? S_CHK_HI : S_W_HI;
                    end
                end
                S_CHK_HI: if (xfer) state <= S_CHK_LO;
                S_CHK_LO: begin
                    if (word_valid)
                        state <= (word == sum) ? S_DONE : S_ERR;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Directed self-checking bench for im_loader.
module tb_im_loader;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Start2 = 1'b0;
    logic [7:0]  ByteIn = 8'h00;
    logic        ByteValid = 1'b0;

    logic        ByteReady, IMWrite, Busy, CPUHold, Done, Error;
    logic [15:0] IMAddr, IMData;
    logic        ByteReady2, IMWrite2, Busy2, CPUHold2, Done2, Error2;
    logic [15:0] IMAddr2, IMData2;

    int checks = 0;
    int errors = 0;

    logic [15:0] wa[$];
    logic [15:0] wd[$];
    logic [15:0] wa2[$];
    logic [15:0] wd2[$];

    always #5 CLK = ~CLK;

    im_loader dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .ByteIn(ByteIn),
        .ByteValid(ByteValid), .ByteReady(ByteReady), .IMAddr(IMAddr),
        .IMData(IMData), .IMWrite(IMWrite), .Busy(Busy),
        .CPUHold(CPUHold), .Done(Done), .Error(Error)
    );

    im_loader #(.BASE_ADDR(16'hFFFF)) dut2 (
        .CLK(CLK), .Reset(Reset), .Start(Start2), .ByteIn(ByteIn),
        .ByteValid(ByteValid), .ByteReady(ByteReady2), .IMAddr(IMAddr2),
        .IMData(IMData2), .IMWrite(IMWrite2), .Busy(Busy2),
        .CPUHold(CPUHold2), .Done(Done2), .Error(Error2)
    );

    always @(negedge CLK) begin
        if (IMWrite) begin
            wa.push_back(IMAddr);
            wd.push_back(IMData);
        end
        if (IMWrite2) begin
            wa2.push_back(IMAddr2);
            wd2.push_back(IMData2);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one byte at a negedge and return on the negedge after it transfers.
    task automatic send(input logic [7:0] b, input bit sel, input bit gaps);
        int n = 0;
        if (gaps && $urandom_range(0, 1) == 1) begin
            ByteValid = 1'b0;
            @(negedge CLK);
        end
        ByteIn = b;
        ByteValid = 1'b1;
        while (!(sel ? ByteReady2 : ByteReady) && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 20) chk("ready_timeout", 32'(sel ? ByteReady2 : ByteReady), 1);
        @(negedge CLK);
    endtask

    task automatic stream(input logic [7:0] bytes[$], input bit sel,
                          input bit gaps);
        foreach (bytes[i]) send(bytes[i], sel, gaps);
        ByteValid = 1'b0;
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) Start2 = 1'b1; else Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        Start2 = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"},   32'(ByteReady), 0);
        chk({tag, "_wr"},    32'(IMWrite), 0);
        chk({tag, "_busy"},  32'(Busy), 0);
        chk({tag, "_hold"},  32'(CPUHold), 0);
        chk({tag, "_done"},  32'(Done), 0);
        chk({tag, "_err"},   32'(Error), 0);
        chk({tag, "_addr"},  32'(IMAddr), 32'h0000);
        chk({tag, "_data"},  32'(IMData), 32'h0000);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        Reset = 1'b0;
        chk_reset_vals("rst");
        chk("rst_addr2", 32'(IMAddr2), 32'hFFFF);

        // ByteValid while idle must not consume or start anything
        ByteValid = 1'b1;
        ByteIn = 8'h55;
        repeat (2) @(negedge CLK);
        ByteValid = 1'b0;
        chk("idle_busy", 32'(Busy), 0);

        // Three-word image
        pulse_start(0);
        chk("start_rdy", 32'(ByteReady), 1);
        chk("start_hold", 32'(CPUHold), 1);
        stream('{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD,
                 8'h00, 8'h01, 8'hBE, 8'h02}, 0, 0);
        chk("t1_done", 32'(Done), 1);
        chk("t1_err", 32'(Error), 0);
        chk("t1_busy", 32'(Busy), 0);
        chk("t1_rdy", 32'(ByteReady), 0);
        chk("t1_nwr", 32'(wa.size()), 3);
        if (wa.size() == 3) begin
            chk("t1_a0", 32'(wa[0]), 32'h0000);
            chk("t1_d0", 32'(wd[0]), 32'h1234);
            chk("t1_a1", 32'(wa[1]), 32'h0001);
            chk("t1_d1", 32'(wd[1]), 32'hABCD);
            chk("t1_a2", 32'(wa[2]), 32'h0002);
            chk("t1_d2", 32'(wd[2]), 32'h0001);
        end
        chk("t1_hold_addr", 32'(IMAddr), 32'h0002);
        chk("t1_hold_data", 32'(IMData), 32'h0001);

        // Empty image, good then bad checksum
        pulse_start(0);
        chk("t2_done_clr", 32'(Done), 0);
        stream('{8'h00, 8'h00, 8'h00, 8'h00}, 0, 0);
        chk("t2_done", 32'(Done), 1);
        chk("t2_nwr", 32'(wa.size()), 3);
        pulse_start(0);
        stream('{8'h00, 8'h00, 8'h00, 8'h01}, 0, 0);
        chk("t2b_err", 32'(Error), 1);
        chk("t2b_done", 32'(Done), 0);

        // Count above MAX_WORDS
        pulse_start(0);
        chk("t3_err_clr", 32'(Error), 0);
        stream('{8'h10, 8'h01}, 0, 0);
        chk("t3_err", 32'(Error), 1);
        chk("t3_busy", 32'(Busy), 0);
        chk("t3_nwr", 32'(wa.size()), 3);

        // Two words with random valid gaps
        pulse_start(0);
        stream('{8'h00, 8'h02, 8'h01, 8'h02, 8'hF0, 8'hF0,
                 8'hF1, 8'hF2}, 0, 1);
        chk("t4_done", 32'(Done), 1);
        chk("t4_nwr", 32'(wa.size()), 5);
        if (wa.size() == 5) begin
            chk("t4_a0", 32'(wa[3]), 32'h0000);
            chk("t4_d0", 32'(wd[3]), 32'h0102);
            chk("t4_a1", 32'(wa[4]), 32'h0001);
            chk("t4_d1", 32'(wd[4]), 32'hF0F0);
        end

        // Reset after the high byte of the first word
        pulse_start(0);
        stream('{8'h00, 8'h02, 8'hAA}, 0, 0);
        chk("t5_busy_pre", 32'(Busy), 1);
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        chk_reset_vals("t5");
        pulse_start(0);
        stream('{8'h00, 8'h01, 8'h55, 8'h66, 8'h55, 8'h66}, 0, 0);
        chk("t5_done", 32'(Done), 1);
        chk("t5_nwr", 32'(wa.size()), 6);
        if (wa.size() == 6) begin
            chk("t5_a", 32'(wa[5]), 32'h0000);
            chk("t5_d", 32'(wd[5]), 32'h5566);
        end

        // Address wrap from FFFF
        pulse_start(1);
        stream('{8'h00, 8'h02, 8'h11, 8'h11, 8'h22, 8'h22,
                 8'h33, 8'h33}, 1, 0);
        chk("t6_done", 32'(Done2), 1);
        chk("t6_nwr", 32'(wa2.size()), 2);
        if (wa2.size() == 2) begin
            chk("t6_a0", 32'(wa2[0]), 32'hFFFF);
            chk("t6_d0", 32'(wd2[0]), 32'h1111);
            chk("t6_a1", 32'(wa2[1]), 32'h0000);
            chk("t6_d1", 32'(wd2[1]), 32'h2222);
        end
        chk("t6_dut1_idle", 32'(wa.size()), 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
